// File: rtl/ifu_fetch_if.sv
// Instruction-memory read port of the fetch stage: a single-beat request
// (req/addr) and a response (rvalid/rdata) that arrives one or more cycles later.
interface ifu_fetch_if;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_rvalid_i;
    logic [31:0] inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_rvalid_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_rvalid_i,
        output inst_rdata_i
    );
endinterface

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, keeps one read outstanding to instruction memory,
// holds one returned word with its static prediction and hands it to if_id.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          PREDICT_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_redirect_i,
    input  logic [31:0] redirect_pc_i,
    ifu_fetch_if.master mem,
    output logic [31:0] pc_o,
    output logic [31:0] ins_o,
    output logic [31:0] next_pc_o,
    output logic        next_taken_o,
    output logic        branch_slot_end_o,
    output logic        stall_req_o
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [6:0]  OPC_JAL  = 7'b1101111;
    localparam logic [6:0]  OPC_BR   = 7'b1100011;

    // REQ: request on the bus; WAIT: awaiting data; FULL: word held;
    // KILL: an outstanding response must be swallowed before the next request.
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    localparam logic [1:0] ST_KILL = 2'd3;

    logic [1:0]  state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] buf_pc_r, buf_ins_r, buf_npc_r;
    logic        buf_tkn_r;
    logic        load_buf_s;
    logic        rd_s;
    logic [31:0] rd_pc_s;
    logic [32:0] pred_s;
    logic        stall_unused_s;

    // Only the if_id hand-off bit of the stall vector concerns this stage.
    assign stall_unused_s = ^{stall_i[5:2], stall_i[0]};

    // Static prediction: {taken, predicted next pc}. JAL always taken,
    // B-type taken only when the offset is negative (backward loop).
    function automatic logic [32:0] predict(input logic [31:0] pc, input logic [31:0] ins);
        logic [31:0] imm_j;
        logic [31:0] imm_b;
        logic [32:0] res;
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        case (ins[6:0])
            OPC_JAL: res = {1'b1, pc + imm_j};
            OPC_BR: begin
                if (ins[31]) begin
                    res = {1'b1, pc + imm_b};
                end else begin
                    res = {1'b0, pc + 32'd4};
                end
            end
            default: res = {1'b0, pc + 32'd4};
        endcase
        if (!PREDICT_EN) begin
            res = {1'b0, pc + 32'd4};
        end else begin
            res = res;
        end
        return res;
    endfunction

    assign pred_s = predict(pc_r, mem.inst_rdata_i);

    // Redirect selection: an exu mispredict outranks a ctrl flush.
    always_comb begin
        if (branch_redirect_i) begin
            rd_s    = 1'b1;
            rd_pc_s = redirect_pc_i;
        end else if (flush_i) begin
            rd_s    = 1'b1;
            rd_pc_s = flush_pc_i;
        end else begin
            rd_s    = 1'b0;
            rd_pc_s = pc_r;
        end
    end

    // Next-state, next-pc and buffer-load decision.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        load_buf_s  = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (rd_s) begin
                    state_nxt_s = ST_KILL;
                    pc_nxt_s    = rd_pc_s;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rd_s) begin
                    state_nxt_s = mem.inst_rvalid_i ? ST_REQ : ST_KILL;
                    pc_nxt_s    = rd_pc_s;
                end else if (mem.inst_rvalid_i) begin
                    state_nxt_s = ST_FULL;
                    load_buf_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_FULL: begin
                if (rd_s) begin
                    state_nxt_s = ST_REQ;
                    pc_nxt_s    = rd_pc_s;
                end else if (!stall_i[1]) begin
                    state_nxt_s = ST_REQ;
                    pc_nxt_s    = buf_npc_r;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_KILL: begin
                if (rd_s) begin
                    pc_nxt_s = rd_pc_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (mem.inst_rvalid_i) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_KILL;
                end
            end
            default: begin
                state_nxt_s = ST_REQ;
                pc_nxt_s    = pc_r;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_r <= ST_REQ;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Instruction buffer, captured together with its prediction.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            buf_pc_r  <= RESET_PC;
            buf_ins_r <= NOP_INST;
            buf_npc_r <= RESET_PC + 32'd4;
            buf_tkn_r <= 1'b0;
        end else if (load_buf_s) begin
            buf_pc_r  <= pc_r;
            buf_ins_r <= mem.inst_rdata_i;
            buf_npc_r <= pred_s[31:0];
            buf_tkn_r <= pred_s[32];
        end else begin
            buf_pc_r  <= buf_pc_r;
            buf_ins_r <= buf_ins_r;
            buf_npc_r <= buf_npc_r;
            buf_tkn_r <= buf_tkn_r;
        end
    end

    assign mem.inst_req_o  = (state_r == ST_REQ);
    assign mem.inst_addr_o = pc_r;

    // Hand-off to if_id: buffer contents when full, a NOP bubble otherwise.
    always_comb begin
        if (state_r == ST_FULL) begin
            pc_o              = buf_pc_r;
            ins_o             = buf_ins_r;
            next_pc_o         = buf_npc_r;
            next_taken_o      = buf_tkn_r;
            branch_slot_end_o = buf_tkn_r;
            stall_req_o       = 1'b0;
        end else begin
            pc_o              = pc_r;
            ins_o             = NOP_INST;
            next_pc_o         = pc_r + 32'd4;
            next_taken_o      = 1'b0;
            branch_slot_end_o = 1'b0;
            stall_req_o       = 1'b1;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, sequential fetch, static prediction,
// redirect/flush handling, stall hold and reset during an outstanding read.
module tb_ifu_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0010_0093;   // addi x1,x0,1
    localparam logic [31:0] BEQB = 32'hFE00_0EE3;   // beq x0,x0,-4
    localparam logic [31:0] JAL  = 32'h1000_00EF;   // jal x1,+0x100
    localparam logic [31:0] BEQF = 32'h0000_0463;   // beq x0,x0,+8

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        branch_redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o, ins_o, next_pc_o;
    logic        next_taken_o, branch_slot_end_o, stall_req_o;

    int vectors    = 0;
    int miscompares = 0;

    ifu_fetch_if mem ();

    ifu_fetch #(.RESET_PC(32'h0000_0000), .PREDICT_EN(1'b1)) dut (
        .clk_i             (clk_i),
        .n_rst_i           (n_rst_i),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .flush_pc_i        (flush_pc_i),
        .branch_redirect_i (branch_redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .mem               (mem),
        .pc_o              (pc_o),
        .ins_o             (ins_o),
        .next_pc_o         (next_pc_o),
        .next_taken_o      (next_taken_o),
        .branch_slot_end_o (branch_slot_end_o),
        .stall_req_o       (stall_req_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Starts in REQ, serves the read with one-cycle latency, ends in FULL.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word,
                         input logic [31:0] npc, input logic tkn);
        chk({tag, ".req"}, {31'd0, mem.inst_req_o}, 32'd1);
        chk({tag, ".addr"}, mem.inst_addr_o, addr);
        tick();
        chk({tag, ".wait_req"}, {31'd0, mem.inst_req_o}, 32'd0);
        chk({tag, ".wait_stall"}, {31'd0, stall_req_o}, 32'd1);
        mem.inst_rvalid_i = 1'b1;
        mem.inst_rdata_i  = word;
        tick();
        mem.inst_rvalid_i = 1'b0;
        mem.inst_rdata_i  = 32'd0;
        chk({tag, ".pc"}, pc_o, addr);
        chk({tag, ".ins"}, ins_o, word);
        chk({tag, ".npc"}, next_pc_o, npc);
        chk({tag, ".tkn"}, {31'd0, next_taken_o}, {31'd0, tkn});
        chk({tag, ".slot"}, {31'd0, branch_slot_end_o}, {31'd0, tkn});
        chk({tag, ".full_stall"}, {31'd0, stall_req_o}, 32'd0);
        chk({tag, ".full_req"}, {31'd0, mem.inst_req_o}, 32'd0);
    endtask

    initial begin
        n_rst_i           = 1'b0;
        stall_i           = 6'd0;
        flush_i           = 1'b0;
        flush_pc_i        = 32'd0;
        branch_redirect_i = 1'b0;
        redirect_pc_i     = 32'd0;
        mem.inst_rvalid_i = 1'b0;
        mem.inst_rdata_i  = 32'd0;
        #1;
        chk("rst.req", {31'd0, mem.inst_req_o}, 32'd1);
        chk("rst.addr", mem.inst_addr_o, 32'h0);
        chk("rst.pc", pc_o, 32'h0);
        chk("rst.ins", ins_o, NOP);
        chk("rst.npc", next_pc_o, 32'h4);
        chk("rst.tkn", {31'd0, next_taken_o}, 32'd0);
        chk("rst.slot", {31'd0, branch_slot_end_o}, 32'd0);
        chk("rst.stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        tick();
        n_rst_i = 1'b1;

        // Sequential fetch of plain ALU words.
        fetch("seq0", 32'h0, ADDI, 32'h4, 1'b0);
        tick();
        fetch("seq4", 32'h4, ADDI, 32'h8, 1'b0);
        tick();
        fetch("seq8", 32'h8, ADDI, 32'hC, 1'b0);

        // Backward branch: predicted taken to 0x0C.
        branch_redirect_i = 1'b1;
        redirect_pc_i     = 32'h10;
        tick();
        branch_redirect_i = 1'b0;
        fetch("bwd", 32'h10, BEQB, 32'hC, 1'b1);
        tick();
        fetch("bwd_tgt", 32'hC, ADDI, 32'h10, 1'b0);

        // JAL always taken.
        branch_redirect_i = 1'b1;
        redirect_pc_i     = 32'h20;
        tick();
        branch_redirect_i = 1'b0;
        fetch("jal", 32'h20, JAL, 32'h120, 1'b1);

        // Flush alone, then a forward branch predicted not taken.
        flush_i    = 1'b1;
        flush_pc_i = 32'h30;
        tick();
        flush_i = 1'b0;
        fetch("fwd", 32'h30, BEQF, 32'h34, 1'b0);

        // Redirect while WAIT; the late response is dropped.
        tick();
        chk("kill.req34", mem.inst_addr_o, 32'h34);
        tick();
        branch_redirect_i = 1'b1;
        redirect_pc_i     = 32'h200;
        tick();
        branch_redirect_i = 1'b0;
        chk("kill.req", {31'd0, mem.inst_req_o}, 32'd0);
        chk("kill.stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        tick();
        mem.inst_rvalid_i = 1'b1;
        mem.inst_rdata_i  = 32'hDEAD_BEEF;
        tick();
        mem.inst_rvalid_i = 1'b0;
        mem.inst_rdata_i  = 32'd0;
        chk("kill.ins", ins_o, NOP);
        fetch("redir", 32'h200, ADDI, 32'h204, 1'b0);

        // flush and redirect together: redirect target wins.
        flush_i           = 1'b1;
        flush_pc_i        = 32'h300;
        branch_redirect_i = 1'b1;
        redirect_pc_i     = 32'h400;
        tick();
        flush_i           = 1'b0;
        branch_redirect_i = 1'b0;
        fetch("prio", 32'h400, JAL, 32'h500, 1'b1);

        // Stall in FULL: outputs frozen, no new request.
        stall_i = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall.pc", pc_o, 32'h400);
            chk("stall.ins", ins_o, JAL);
            chk("stall.req", {31'd0, mem.inst_req_o}, 32'd0);
            chk("stall.sreq", {31'd0, stall_req_o}, 32'd0);
        end
        stall_i = 6'd0;
        tick();
        chk("unstall.addr", mem.inst_addr_o, 32'h500);
        chk("unstall.req", {31'd0, mem.inst_req_o}, 32'd1);

        // Reset while a read is outstanding.
        tick();
        n_rst_i = 1'b0;
        #1;
        chk("mrst.req", {31'd0, mem.inst_req_o}, 32'd1);
        chk("mrst.addr", mem.inst_addr_o, 32'h0);
        chk("mrst.ins", ins_o, NOP);
        chk("mrst.stall", {31'd0, stall_req_o}, 32'd1);
        mem.inst_rvalid_i = 1'b1;
        mem.inst_rdata_i  = 32'hDEAD_BEEF;
        tick();
        n_rst_i = 1'b1;
        chk("mrst.rel_addr", mem.inst_addr_o, 32'h0);
        tick();
        mem.inst_rvalid_i = 1'b0;
        mem.inst_rdata_i  = 32'd0;
        chk("mrst.stale_stall", {31'd0, stall_req_o}, 32'd1);
        chk("mrst.stale_ins", ins_o, NOP);
        chk("mrst.stale_req", {31'd0, mem.inst_req_o}, 32'd0);
        mem.inst_rvalid_i = 1'b1;
        mem.inst_rdata_i  = ADDI;
        tick();
        mem.inst_rvalid_i = 1'b0;
        chk("mrst.pc", pc_o, 32'h0);
        chk("mrst.ins_ok", ins_o, ADDI);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
